// File: rtl/neopixel_axil_tx.sv
// AXI4-Lite slave that drives a WS2812 serial line: COLOR (GRB) is repeated
// COUNT times, MSB first, then the line is held low for a latch gap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a start write; DOUT low; busy=0
// ST_HIGH  | high phase of the current bit (T0H or T1H cycles)
// ST_LOW   | low remainder of the bit period (TBIT minus high time)
// ST_LATCH | reset/latch gap after the last bit (TLATCH cycles low)
module neopixel_axil_tx #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int T0H                = 40,
   parameter int T1H                = 80,
   parameter int TBIT               = 125,
   parameter int TLATCH             = 5000
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            DOUT
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   localparam int TW = 16;
   localparam logic [TW-1:0] L_T0H_M1    = TW'(T0H - 1);
   localparam logic [TW-1:0] L_T1H_M1    = TW'(T1H - 1);
   localparam logic [TW-1:0] L_T0L_M1    = TW'(TBIT - T0H - 1);
   localparam logic [TW-1:0] L_T1L_M1    = TW'(TBIT - T1H - 1);
   localparam logic [TW-1:0] L_TLATCH_M1 = TW'(TLATCH - 1);

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_COLOR  = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   // Bus-facing registers
   logic                          r_awready;
   logic                          r_bvalid;
   logic                          r_arready;
   logic                          r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

   // Configuration and frame state
   logic [23:0]   r_color;
   logic [15:0]   r_count;
   logic          r_done;
   logic [23:0]   r_sh_color;
   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [4:0]    r_bit_idx;
   logic [15:0]   r_pix_cnt;
   logic          r_dout;

   state_t        w_state_nxt;
   logic [TW-1:0] w_timer_nxt;
   logic [4:0]    w_bit_nxt;
   logic [15:0]   w_pix_nxt;
   logic          w_frame_end;
   logic [4:0]    w_bit_dec;

   logic                          w_wr_en;
   logic [1:0]                    w_wr_sel;
   logic                          w_rd_en;
   logic [1:0]                    w_rd_sel;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_mux;
   logic                          w_busy;
   logic                          w_start_req;
   logic                          w_start_run;
   logic                          w_start_zero;
   logic                          w_clr_done;
   logic                          w_unused;

   function automatic logic [TW-1:0] f_high_m1(input logic b);
      return b ? L_T1H_M1 : L_T0H_M1;
   endfunction

   function automatic logic [TW-1:0] f_low_m1(input logic b);
      return b ? L_T1L_M1 : L_T0L_M1;
   endfunction

   assign w_busy   = (r_state != ST_IDLE);
   assign w_wr_en  = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
   assign w_wr_sel = S_AXI_AWADDR[3:2];
   assign w_rd_en  = r_arready & S_AXI_ARVALID;
   assign w_rd_sel = S_AXI_ARADDR[3:2];

   assign w_start_req  = w_wr_en & (w_wr_sel == A_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[0] & ~w_busy;
   assign w_start_run  = w_start_req & (r_count != 16'd0);
   assign w_start_zero = w_start_req & (r_count == 16'd0);
   assign w_clr_done   = w_wr_en & (w_wr_sel == A_STATUS) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];

   assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:24], S_AXI_WSTRB[3]};

   // Write channel: one-cycle ready pulse, response held until taken
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
         if (w_wr_en)
            r_bvalid <= 1'b1;
         else if (S_AXI_BREADY)
            r_bvalid <= 1'b0;
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (w_rd_sel)
         A_CTRL:   w_rd_mux[0]    = w_busy;
         A_COLOR:  w_rd_mux[23:0] = r_color;
         A_COUNT:  w_rd_mux[15:0] = r_count;
         default:  w_rd_mux[1:0]  = {r_done, w_busy};
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;
         if (w_rd_en) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
         end else if (S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_color    <= '0;
         r_count    <= '0;
         r_done     <= 1'b0;
         r_sh_color <= '0;
      end else begin
         if (w_wr_en && w_wr_sel == A_COLOR) begin
            for (int b = 0; b < 3; b++)
               if (S_AXI_WSTRB[b]) r_color[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end
         if (w_wr_en && w_wr_sel == A_COUNT) begin
            for (int b = 0; b < 2; b++)
               if (S_AXI_WSTRB[b]) r_count[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         end
         if (w_start_run)
            r_sh_color <= r_color;
         // A completing frame beats a simultaneous W1C
         if (w_frame_end || w_start_zero)
            r_done <= 1'b1;
         else if (w_clr_done || w_start_run)
            r_done <= 1'b0;
      end
   end

   assign w_bit_dec = r_bit_idx - 5'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_bit_nxt   = r_bit_idx;
      w_pix_nxt   = r_pix_cnt;
      w_frame_end = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_run) begin
               w_state_nxt = ST_HIGH;
               w_timer_nxt = f_high_m1(r_color[23]);
               w_bit_nxt   = 5'd23;
               w_pix_nxt   = r_count;
            end
         end
         ST_HIGH: begin
            if (r_timer == '0) begin
               w_state_nxt = ST_LOW;
               w_timer_nxt = f_low_m1(r_sh_color[r_bit_idx]);
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         ST_LOW: begin
            if (r_timer != '0) begin
               w_timer_nxt = r_timer - 1'b1;
            end else if (r_bit_idx != 5'd0) begin
               w_state_nxt = ST_HIGH;
               w_bit_nxt   = w_bit_dec;
               w_timer_nxt = f_high_m1(r_sh_color[w_bit_dec]);
            end else if (r_pix_cnt == 16'd1) begin
               w_state_nxt = ST_LATCH;
               w_pix_nxt   = 16'd0;
               w_timer_nxt = L_TLATCH_M1;
            end else begin
               w_state_nxt = ST_HIGH;
               w_pix_nxt   = r_pix_cnt - 16'd1;
               w_bit_nxt   = 5'd23;
               w_timer_nxt = f_high_m1(r_sh_color[23]);
            end
         end
         ST_LATCH: begin
            if (r_timer == '0) begin
               w_state_nxt = ST_IDLE;
               w_frame_end = 1'b1;
            end else begin
               w_timer_nxt = r_timer - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state   <= ST_IDLE;
         r_timer   <= '0;
         r_bit_idx <= '0;
         r_pix_cnt <= '0;
         r_dout    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_bit_idx <= w_bit_nxt;
         r_pix_cnt <= w_pix_nxt;
         r_dout    <= (w_state_nxt == ST_HIGH);
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_awready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = 2'b00;
   assign DOUT          = r_dout;

endmodule

// File: tb/tb_neopixel_axil_tx.sv
// Bench for neopixel_axil_tx: register behaviour against a register model,
// serial frames against a pulse list derived from colour, count and timing.
module tb_neopixel_axil_tx;

   localparam int T0H = 40, T1H = 80, TBIT = 125, TLATCH = 5000;
   localparam logic [3:0] A_CTRL = 4'h0, A_COLOR = 4'h4, A_COUNT = 4'h8, A_STATUS = 4'hC;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b1;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic        DOUT;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   logic [23:0] m_color;
   logic [15:0] m_count;

   neopixel_axil_tx dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
      .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
      .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
      .S_AXI_RREADY(S_AXI_RREADY), .DOUT(DOUT)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      int k;
      @(posedge ACLK); #1;
      S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
      k = 0;
      while (!S_AXI_AWREADY && k < 20) begin @(posedge ACLK); #1; k++; end
      if (k >= 20) begin
         n_total++;
         $display("FAIL write_accept_timeout addr=%h: no AWREADY within 20 cycles", addr);
         S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
         resp = 2'b11;
         return;
      end
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      k = 0;
      while (!S_AXI_BVALID && k < 20) begin @(posedge ACLK); #1; k++; end
      if (k >= 20) begin
         n_total++;
         $display("FAIL write_resp_timeout addr=%h: no BVALID within 20 cycles", addr);
         S_AXI_BREADY = 1'b0;
         resp = 2'b11;
         return;
      end
      resp = S_AXI_BRESP;
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int k;
      @(posedge ACLK); #1;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
      k = 0;
      while (!S_AXI_ARREADY && k < 20) begin @(posedge ACLK); #1; k++; end
      if (k >= 20) begin
         n_total++;
         $display("FAIL read_accept_timeout addr=%h: no ARREADY within 20 cycles", addr);
         S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
         data = 32'hDEAD_BEEF; resp = 2'b11;
         return;
      end
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      k = 0;
      while (!S_AXI_RVALID && k < 20) begin @(posedge ACLK); #1; k++; end
      if (k >= 20) begin
         n_total++;
         $display("FAIL read_resp_timeout addr=%h: no RVALID within 20 cycles", addr);
         S_AXI_RREADY = 1'b0;
         data = 32'hDEAD_BEEF; resp = 2'b11;
         return;
      end
      data = S_AXI_RDATA; resp = S_AXI_RRESP;
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [1:0]  r;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0;
      S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0; S_AXI_ARADDR = '0;
      S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      #2 ARESETN = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      n_total++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
           S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP, DOUT} !== 42'h0)
         $display("FAIL reset_outputs got=%h expected=0", {S_AXI_AWREADY, S_AXI_WREADY,
                  S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP, DOUT});
      else n_pass++;
      @(negedge ACLK) ARESETN = 1'b1;
      for (int a = 0; a < 4; a++) begin
         axi_read(4'(a * 4), d, r);
         n_total++;
         if ({r, d} !== 34'h0) $display("FAIL reset_reg%0d got=%h resp=%b expected=0", a, d, r);
         else n_pass++;
      end
      m_color = '0; m_count = '0;
   endtask

   task automatic test_regs();
      logic [31:0] d;
      logic [1:0]  r, racc;
      int          t_lim;
      racc = 2'b00;
      axi_write(A_COLOR, 32'h2, 4'hF, r);  racc |= r;
      axi_write(A_COUNT, 32'h3, 4'hF, r);  racc |= r;
      axi_write(A_STATUS, 32'h4, 4'hF, r); racc |= r;
      axi_write(A_CTRL, 32'h1, 4'hF, r);   racc |= r;
      m_color = 24'h2; m_count = 16'h3;
      axi_read(A_COLOR, d, r); racc |= r;
      n_total++; if (d !== 32'h2) $display("FAIL regs_color got=%h expected=00000002", d); else n_pass++;
      axi_read(A_COUNT, d, r); racc |= r;
      n_total++; if (d !== 32'h3) $display("FAIL regs_count got=%h expected=00000003", d); else n_pass++;
      axi_read(A_CTRL, d, r); racc |= r;
      n_total++; if (d !== 32'h1) $display("FAIL regs_ctrl_busy got=%h expected=00000001", d); else n_pass++;
      axi_read(A_STATUS, d, r); racc |= r;
      n_total++; if (d !== 32'h1) $display("FAIL regs_status_busy got=%h expected=00000001", d); else n_pass++;
      n_total++; if (racc !== 2'b00) $display("FAIL regs_resp got=%b expected=00", racc); else n_pass++;
      t_lim = cyc + 3 * 24 * TBIT + TLATCH + 500;
      d = 32'h1;
      while (d[0] === 1'b1 && cyc < t_lim) axi_read(A_STATUS, d, r);
      n_total++; if (d !== 32'h2) $display("FAIL regs_done got=%h expected=00000002", d); else n_pass++;
      axi_write(A_STATUS, 32'h2, 4'h1, r);
      axi_read(A_STATUS, d, r);
      n_total++; if (d !== 32'h0) $display("FAIL regs_w1c got=%h expected=00000000", d); else n_pass++;
   endtask

   task automatic test_random_regs();
      logic [31:0] d, data;
      logic [3:0]  a, strb;
      logic [1:0]  r;
      for (int it = 0; it < 8; it++) begin
         a = ($urandom_range(0, 1) == 0) ? A_COLOR : A_COUNT;
         data = $urandom;
         strb = 4'($urandom_range(0, 15));
         axi_write(a, data, strb, r);
         for (int b = 0; b < 3; b++)
            if (a == A_COLOR && strb[b]) m_color[8*b +: 8] = data[8*b +: 8];
         for (int b = 0; b < 2; b++)
            if (a == A_COUNT && strb[b]) m_count[8*b +: 8] = data[8*b +: 8];
         axi_read(A_COLOR, d, r);
         n_total++;
         if (d !== {8'h0, m_color}) $display("FAIL rand_color it=%0d got=%h expected=%h", it, d, {8'h0, m_color});
         else n_pass++;
         axi_read(A_COUNT, d, r);
         n_total++;
         if (d !== {16'h0, m_count}) $display("FAIL rand_count it=%0d got=%h expected=%h", it, d, {16'h0, m_count});
         else n_pass++;
      end
      axi_write(A_COUNT, 32'h5, 4'hF, r);
      m_count = 16'h5;
      axi_write(A_CTRL, 32'hFFFF_FFFF, 4'hE, r);
      axi_read(A_CTRL, d, r);
      n_total++;
      if (d !== 32'h0) $display("FAIL ctrl_no_strb_no_start got=%h expected=00000000", d); else n_pass++;
   endtask

   task automatic test_simultaneous();
      logic [31:0] d, dnew;
      logic [1:0]  rw, rr;
      dnew = {8'h0, 24'($urandom)} ^ {8'h0, m_color} ^ 32'h0000_0101;
      fork
         axi_write(A_COLOR, dnew, 4'hF, rw);
         axi_read(A_COLOR, d, rr);
      join
      n_total++;
      if ({rw, rr, d} !== {4'b0000, 8'h0, m_color})
         $display("FAIL simul_read_old got=%h resp=%b/%b expected=%h", d, rw, rr, {8'h0, m_color});
      else n_pass++;
      m_color = dnew[23:0];
      axi_read(A_COLOR, d, rr);
      n_total++;
      if (d !== {8'h0, m_color}) $display("FAIL simul_write_took got=%h expected=%h", d, {8'h0, m_color});
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] d, d0;
      logic [1:0]  r;
      int          rdy_hi, bv_lo, ar_hi, rv_lo, rd_chg, k;
      axi_write(A_COLOR, 32'hAABBCC, 4'hF, r);
      @(posedge ACLK); #1;
      S_AXI_AWADDR = A_COLOR; S_AXI_WDATA = 32'h11; S_AXI_WSTRB = 4'h1;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      k = 0;
      while (!S_AXI_AWREADY && k < 20) begin @(posedge ACLK); #1; k++; end
      @(posedge ACLK); #1;
      rdy_hi = 0; bv_lo = 0;
      for (int i = 0; i < 10; i++) begin
         if (S_AXI_AWREADY || S_AXI_WREADY) rdy_hi++;
         if (!S_AXI_BVALID) bv_lo++;
         @(posedge ACLK); #1;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b0;
      n_total++;
      if (rdy_hi != 0 || bv_lo != 0 || k >= 20)
         $display("FAIL bp_write_hold ready_pulses=%0d bvalid_drops=%0d expected 0/0", rdy_hi, bv_lo);
      else n_pass++;
      m_color = 24'hAABB11;
      axi_read(A_COLOR, d, r);
      n_total++;
      if (d !== 32'h00AABB11) $display("FAIL bp_strobe_color got=%h expected=00aabb11", d); else n_pass++;

      @(posedge ACLK); #1;
      S_AXI_ARADDR = A_COLOR; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
      k = 0;
      while (!S_AXI_ARREADY && k < 20) begin @(posedge ACLK); #1; k++; end
      @(posedge ACLK); #1;
      d0 = S_AXI_RDATA;
      ar_hi = 0; rv_lo = 0; rd_chg = 0;
      fork
         axi_write(A_COLOR, 32'h123456, 4'hF, r);
         for (int i = 0; i < 10; i++) begin
            if (S_AXI_ARREADY) ar_hi++;
            if (!S_AXI_RVALID) rv_lo++;
            if (S_AXI_RDATA !== d0) rd_chg++;
            @(posedge ACLK); #1;
         end
      join
      m_color = 24'h123456;
      S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b0;
      n_total++;
      if (d0 !== 32'h00AABB11 || k >= 20) $display("FAIL bp_read_data got=%h expected=00aabb11", d0);
      else n_pass++;
      n_total++;
      if (ar_hi != 0 || rv_lo != 0 || rd_chg != 0)
         $display("FAIL bp_read_hold arready=%0d rvalid_drops=%0d rdata_changes=%0d expected 0/0/0", ar_hi, rv_lo, rd_chg);
      else n_pass++;
      n_total++;
      if (S_AXI_RVALID !== 1'b0) $display("FAIL bp_read_release rvalid=%b expected=0", S_AXI_RVALID); else n_pass++;
   endtask

   task automatic test_zero_count();
      logic [31:0] d;
      logic [1:0]  r;
      int          highs;
      axi_write(A_STATUS, 32'h2, 4'h1, r);
      axi_write(A_COUNT, 32'h0, 4'hF, r);
      m_count = '0;
      highs = 0;
      fork
         axi_write(A_CTRL, 32'h1, 4'h1, r);
         for (int i = 0; i < 60; i++) begin @(posedge ACLK); #1; if (DOUT) highs++; end
      join
      axi_read(A_STATUS, d, r);
      n_total++;
      if (d !== 32'h2) $display("FAIL zero_count_status got=%h expected=00000002", d); else n_pass++;
      n_total++;
      if (highs != 0) $display("FAIL zero_count_dout high_cycles=%0d expected=0", highs); else n_pass++;
   endtask

   task automatic test_frame(input logic [23:0] color, input logic [15:0] count, input bit disturb);
      logic [31:0] d;
      logic [1:0]  r, r2;
      logic        dq[$];
      int          cq[$], widths[$], rises[$], expw[$];
      int          nb, ncap, run, c0, bad_w, bad_p, highs, tgt;
      axi_write(A_STATUS, 32'h2, 4'h1, r);
      axi_write(A_COLOR, {8'h0, color}, 4'hF, r);
      axi_write(A_COUNT, {16'h0, count}, 4'hF, r);
      m_color = color; m_count = count;
      nb = int'(count) * 24;
      ncap = nb * TBIT + 20;
      fork
         axi_write(A_CTRL, 32'h1, 4'h1, r);
         for (int i = 0; i < ncap; i++) begin
            @(posedge ACLK); #1;
            dq.push_back(DOUT); cq.push_back(cyc);
         end
         if (disturb) begin
            repeat (TBIT * 30) @(posedge ACLK);
            axi_write(A_COLOR, 32'h00FF00, 4'hF, r2);
            axi_write(A_CTRL, 32'h1, 4'h1, r2);
            axi_read(A_STATUS, d, r2);
            n_total++;
            if (d !== 32'h1) $display("FAIL frame_midrun_status got=%h expected=00000001", d); else n_pass++;
         end
      join
      if (disturb) m_color = 24'h00FF00;
      for (int p = 0; p < int'(count); p++)
         for (int b = 23; b >= 0; b--) expw.push_back(color[b] ? T1H : T0H);
      run = 0;
      for (int i = 0; i < dq.size(); i++) begin
         if (dq[i]) begin
            if (run == 0) rises.push_back(i);
            run++;
         end else begin
            if (run > 0) widths.push_back(run);
            run = 0;
         end
      end
      if (run > 0) widths.push_back(run);
      n_total++;
      if (widths.size() != nb) $display("FAIL frame_bits color=%h got=%0d expected=%0d", color, widths.size(), nb);
      else n_pass++;
      bad_w = -1;
      for (int i = 0; i < widths.size() && i < nb; i++)
         if (bad_w < 0 && widths[i] != expw[i]) bad_w = i;
      n_total++;
      if (bad_w >= 0) $display("FAIL frame_width color=%h bit=%0d got=%0d expected=%0d", color, bad_w, widths[bad_w], expw[bad_w]);
      else n_pass++;
      bad_p = 0;
      for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != TBIT) bad_p++;
      n_total++;
      if (bad_p != 0 || rises.size() == 0) $display("FAIL frame_period bad_periods=%0d rises=%0d expected period=%0d", bad_p, rises.size(), TBIT);
      else n_pass++;
      c0 = (rises.size() > 0) ? cq[rises[0]] : cyc;
      highs = 0;
      tgt = c0 + nb * TBIT + TLATCH - 30;
      while (cyc < tgt) begin @(posedge ACLK); #1; if (DOUT) highs++; end
      axi_read(A_STATUS, d, r);
      n_total++;
      if (d !== 32'h1) $display("FAIL frame_latch_busy got=%h expected=00000001", d); else n_pass++;
      tgt = c0 + nb * TBIT + TLATCH + 5;
      while (cyc < tgt) begin @(posedge ACLK); #1; if (DOUT) highs++; end
      axi_read(A_STATUS, d, r);
      n_total++;
      if (d !== 32'h2) $display("FAIL frame_done got=%h expected=00000002", d); else n_pass++;
      n_total++;
      if (highs != 0) $display("FAIL frame_latch_low high_cycles=%0d expected=0", highs); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d;
      logic [1:0]  r;
      int          c0, highs;
      axi_write(A_STATUS, 32'h2, 4'h1, r);
      axi_write(A_COLOR, {8'h0, 24'($urandom)}, 4'hF, r);
      axi_write(A_COUNT, 32'h1, 4'hF, r);
      axi_read(A_COUNT, d, r);
      c0 = -1;
      fork
         axi_write(A_CTRL, 32'h1, 4'h1, r);
         for (int i = 0; i < 30 && c0 < 0; i++) begin @(posedge ACLK); #1; if (DOUT) c0 = cyc; end
      join
      n_total++;
      if (c0 < 0) begin
         $display("FAIL midreset_start: DOUT never rose within 30 cycles");
      end else begin
         n_pass++;
         while (cyc < c0 + 10 * TBIT + 2) begin @(posedge ACLK); #1; end
         n_total++;
         if (DOUT !== 1'b1) $display("FAIL midreset_dout_before got=%b expected=1", DOUT); else n_pass++;
         #2 ARESETN = 1'b0;
         #1;
         n_total++;
         if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
              S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP, DOUT} !== 42'h0)
            $display("FAIL midreset_outputs got=%h expected=0", {S_AXI_AWREADY, S_AXI_WREADY,
                     S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP, DOUT});
         else n_pass++;
      end
      ARESETN = 1'b0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK) ARESETN = 1'b1;
      m_color = '0; m_count = '0;
      highs = 0;
      for (int i = 0; i < 200; i++) begin @(posedge ACLK); #1; if (DOUT) highs++; end
      n_total++;
      if (highs != 0) $display("FAIL midreset_dout_after high_cycles=%0d expected=0", highs); else n_pass++;
      axi_read(A_STATUS, d, r);
      n_total++;
      if (d !== 32'h0) $display("FAIL midreset_status got=%h expected=00000000", d); else n_pass++;
      axi_read(A_COLOR, d, r);
      n_total++;
      if (d !== {8'h0, m_color}) $display("FAIL midreset_color got=%h expected=%h", d, {8'h0, m_color}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_regs();
      test_random_regs();
      test_simultaneous();
      test_backpressure();
      test_zero_count();
      test_frame(24'hFF0000, 16'd1, 1'b0);
      test_frame(24'h0F0F0F, 16'd2, 1'b1);
      test_frame(24'($urandom), 16'd1, 1'b0);
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
